// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller: pointers, occupancy FSM, threshold flags and flush for a dual-port RAM.
// Optional FIFO_CTRL_ERR_EN adds sticky overflow_o/underflow_o outputs.
module fifo_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 8,
    parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_0_o,
    output logic                  ram_ce_0_o,
    output logic                  ram_wr_0_o,
    output logic [DATA_WIDTH-1:0] ram_data_0_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_1_o,
    output logic                  ram_ce_1_o,
    output logic                  ram_wr_1_o,
    input  logic [DATA_WIDTH-1:0] ram_data_1_i
`ifdef FIFO_CTRL_ERR_EN
    ,
    output logic                  overflow_o,
    output logic                  underflow_o
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AFULL_C  = AFULL_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = AEMPTY_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] ONE_C    = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t              state_q;
    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                afull_q, aempty_q;
    logic                push_acc, pop_acc;

    assign empty_o = (state_q == ST_EMPTY);
    assign full_o  = (state_q == ST_FULL);

    // Gating with rst_n keeps the RAM write strobe quiet while reset is held.
    assign push_acc = rst_n & push_i & ~full_o & ~flush_i;
    assign pop_acc  = rst_n & pop_i & ~empty_o & ~flush_i;

    assign count_o        = count_q;
    assign almost_full_o  = afull_q;
    assign almost_empty_o = aempty_q;
    assign pop_data_o     = ram_data_1_i;

    assign ram_addr_0_o = wr_ptr_q[ADDR_WIDTH-1:0];
    assign ram_ce_0_o   = push_acc;
    assign ram_wr_0_o   = push_acc;
    assign ram_data_0_o = push_acc ? push_data_i : '0;
    assign ram_addr_1_o = rd_ptr_q[ADDR_WIDTH-1:0];
    assign ram_ce_1_o   = ~empty_o;
    assign ram_wr_1_o   = 1'b0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_acc) wr_ptr_d = wr_ptr_q + ONE_C;
            if (pop_acc)  rd_ptr_d = rd_ptr_q + ONE_C;
            case ({push_acc, pop_acc})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            afull_q  <= (count_d >= AFULL_C);
            aempty_q <= (count_d <= AEMPTY_C);
            if (flush_i) begin
                state_q <= ST_EMPTY;
            end else begin
                case (state_q)
                    ST_EMPTY:
                        if (push_acc && !pop_acc) state_q <= ST_PARTIAL;
                    ST_PARTIAL:
                        if (pop_acc && !push_acc && count_q == ONE_C)
                            state_q <= ST_EMPTY;
                        else if (push_acc && !pop_acc && count_q == DEPTH_C - ONE_C)
                            state_q <= ST_FULL;
                    ST_FULL:
                        if (pop_acc) state_q <= ST_PARTIAL;
                    default:
                        state_q <= ST_EMPTY;
                endcase
            end
        end
    end

`ifdef FIFO_CTRL_ERR_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (flush_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push_i && full_o)  overflow_q  <= 1'b1;
            if (pop_i  && empty_o) underflow_q <= 1'b1;
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`endif

    // State register and count are kept separately; they must never disagree.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (count_q == wr_ptr_q - rd_ptr_q
                    && ((state_q == ST_EMPTY) == (count_q == '0))
                    && ((state_q == ST_FULL) == (count_q == DEPTH_C)));
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: directed plan plus random traffic checked against a queue-based FIFO model.
module tb_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AFT   = 3;
    localparam int AET   = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          push, pop, flush;
    logic [DW-1:0] push_data;
    logic [DW-1:0] pop_data;
    logic          full, empty, almost_full, almost_empty;
    logic [AW:0]   count;
    logic [AW-1:0] ram_addr_0, ram_addr_1;
    logic          ram_ce_0, ram_wr_0, ram_ce_1, ram_wr_1;
    logic [DW-1:0] ram_data_0, ram_data_1;
`ifdef FIFO_CTRL_ERR_EN
    logic          overflow, underflow;
`endif

    always #5 clk = ~clk;

    fifo_ctrl #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .AFULL_THRESH (AFT),
        .AEMPTY_THRESH(AET)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .push_i        (push),
        .push_data_i   (push_data),
        .pop_i         (pop),
        .flush_i       (flush),
        .pop_data_o    (pop_data),
        .full_o        (full),
        .empty_o       (empty),
        .almost_full_o (almost_full),
        .almost_empty_o(almost_empty),
        .count_o       (count),
        .ram_addr_0_o  (ram_addr_0),
        .ram_ce_0_o    (ram_ce_0),
        .ram_wr_0_o    (ram_wr_0),
        .ram_data_0_o  (ram_data_0),
        .ram_addr_1_o  (ram_addr_1),
        .ram_ce_1_o    (ram_ce_1),
        .ram_wr_1_o    (ram_wr_1),
        .ram_data_1_i  (ram_data_1)
`ifdef FIFO_CTRL_ERR_EN
        ,
        .overflow_o    (overflow),
        .underflow_o   (underflow)
`endif
    );

    // Dual-port RAM stand-in: synchronous write, combinational read.
    logic [DW-1:0] mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    always @(posedge clk) if (ram_ce_0 && ram_wr_0) mem[ram_addr_0] <= ram_data_0;
    assign ram_data_1 = mem[ram_addr_1];

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] q[$];
    int wr_p, rd_p;
    bit ovf_m, unf_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        wr_p  = 0;
        rd_p  = 0;
        ovf_m = 1'b0;
        unf_m = 1'b0;
    endtask

    task automatic check_state();
        int sz;
        sz = q.size();
        chk("count", 32'(count), sz);
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("full", 32'(full), 32'(sz == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(sz >= AFT));
        chk("almost_empty", 32'(almost_empty), 32'(sz <= AET));
        chk("wr_ptr_msb", 32'(dut.wr_ptr_q[AW]), (wr_p >> AW) & 1);
`ifdef FIFO_CTRL_ERR_EN
        chk("overflow", 32'(overflow), 32'(ovf_m));
        chk("underflow", 32'(underflow), 32'(unf_m));
`endif
    endtask

    task automatic step(input bit ps, input logic [DW-1:0] d, input bit pp, input bit fl);
        int sz;
        bit acc_push, acc_pop;
        @(negedge clk);
        push = ps; push_data = d; pop = pp; flush = fl;
        #1;
        sz       = q.size();
        acc_push = ps && (sz < DEPTH) && !fl;
        acc_pop  = pp && (sz > 0) && !fl;
        chk("ram_ce_0", 32'(ram_ce_0), 32'(acc_push));
        chk("ram_wr_0", 32'(ram_wr_0), 32'(acc_push));
        if (acc_push) begin
            chk("ram_addr_0", 32'(ram_addr_0), wr_p % DEPTH);
            chk("ram_data_0", 32'(ram_data_0), 32'(d));
        end
        chk("ram_ce_1", 32'(ram_ce_1), 32'(sz > 0));
        chk("ram_wr_1", 32'(ram_wr_1), 0);
        if (sz > 0) begin
            chk("ram_addr_1", 32'(ram_addr_1), rd_p % DEPTH);
            chk("pop_data", 32'(pop_data), 32'(q[0]));
        end
        @(posedge clk);
        if (fl) begin
            model_reset();
        end else begin
            if (ps && sz == DEPTH) ovf_m = 1'b1;
            if (pp && sz == 0)     unf_m = 1'b1;
            if (acc_pop) begin
                void'(q.pop_front());
                rd_p = (rd_p + 1) % (2 * DEPTH);
            end
            if (acc_push) begin
                q.push_back(d);
                wr_p = (wr_p + 1) % (2 * DEPTH);
            end
        end
        #1;
        check_state();
        push = 1'b0; pop = 1'b0; flush = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_almost_empty", 32'(almost_empty), 1);
        chk("rst_almost_full", 32'(almost_full), 0);
        chk("rst_ram_ce_0", 32'(ram_ce_0), 0);
        chk("rst_ram_wr_0", 32'(ram_wr_0), 0);
        chk("rst_ram_addr_0", 32'(ram_addr_0), 0);
        chk("rst_ram_ce_1", 32'(ram_ce_1), 0);
        chk("rst_ram_addr_1", 32'(ram_addr_1), 0);
`ifdef FIFO_CTRL_ERR_EN
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_underflow", 32'(underflow), 0);
`endif
    endtask

    initial begin
        logic [DW-1:0] d;
        rst_n = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; push_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Idle cycles leave the reset state untouched.
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);

        // Fill to full, then one ignored push.
        for (int i = 0; i < DEPTH; i++) step(1, 8'hA1 + 8'(i), 0, 0);
        chk("full_after_fill", 32'(full), 1);
        step(1, 8'hA5, 0, 0);

        // Drain in order, then one ignored pop.
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0);
        chk("empty_after_drain", 32'(empty), 1);
        step(0, 8'h00, 1, 0);

        // Hold count at 2 with simultaneous traffic; addresses wrap around.
        step(1, 8'h10, 0, 0);
        step(1, 8'h11, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 8'h20 + 8'(i), 1, 0);
        chk("count_steady", 32'(count), 2);

        // Flush with a concurrent push: nothing written, everything cleared.
        step(1, 8'h30, 0, 0);
        step(1, 8'h31, 0, 0);
        step(1, 8'h32, 0, 0);
        step(1, 8'h33, 0, 1);
        chk("count_after_flush", 32'(count), 0);

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            d = 8'($urandom);
            step(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 24) == 0));
        end

        // Asynchronous reset mid-burst at count 3.
        step(1, 8'h00, 0, 1);
        step(1, 8'h41, 0, 0);
        step(1, 8'h42, 0, 0);
        step(1, 8'h43, 0, 0);
        chk("count_before_reset", 32'(count), 3);
        @(negedge clk);
        push = 1'b1; push_data = 8'h44;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        push = 1'b0;
        rst_n = 1'b1;
        step(1, 8'h55, 0, 0);
        step(0, 8'h00, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
